// File: rtl/udt_tx_arbiter_if.sv
// udt_tx_arbiter_if: AXI-stream packet channel carrying a per-packet UDP destination
interface udt_tx_arbiter_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [31:0] ip_dest;
    logic [15:0] port_dest;
    modport master(output tvalid, tlast, tdata, tkeep, ip_dest, port_dest, input tready);
    modport slave(input tvalid, tlast, tdata, tkeep, ip_dest, port_dest, output tready);
endinterface

// File: rtl/udt_tx_arbiter.sv
// udt_tx_arbiter: packet-atomic control/data arbiter onto the UDP transmit channel
module udt_tx_arbiter #(
    parameter int          MAX_CTRL_BURST = 4,
    parameter logic [47:0] FPGA_MAC_SRC   = 48'hba0203040506,
    parameter logic [47:0] FPGA_MAC_DES   = 48'hffffffffffff,
    parameter logic [31:0] FPGA_IP_SRC    = 32'hc0a8006f,
    parameter int          PORT           = 10086
) (
    input  logic                    udp_clk,
    input  logic                    udp_areset,
    input  logic                    arb_enable,
    udt_tx_arbiter_if.slave         ctrl,
    udt_tx_arbiter_if.slave         data,
    udt_tx_arbiter_if.master        udp_tx,
    output logic [47:0]             udp_tx_mac_src,
    output logic [47:0]             udp_tx_mac_dest,
    output logic [31:0]             udp_tx_ip_src,
    output logic [15:0]             udp_tx_port_src,
    output logic                    busy,
    output logic [31:0]             ctrl_pkt_cnt,
    output logic [31:0]             data_pkt_cnt
);
    typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;
    localparam logic [3:0] BURST_MAX = 4'(MAX_CTRL_BURST);
    state_t     state, nxt;
    logic [3:0] burst;
    logic       idle, grant_ctrl, grant_data, done;
    assign udp_tx_mac_src  = FPGA_MAC_SRC;
    assign udp_tx_mac_dest = FPGA_MAC_DES;
    assign udp_tx_ip_src   = FPGA_IP_SRC;
    assign udp_tx_port_src = 16'(PORT);
    always_comb begin
        idle       = state == IDLE;
        grant_ctrl = arb_enable && ctrl.tvalid && (!data.tvalid || burst < BURST_MAX);
        grant_data = arb_enable && !grant_ctrl && data.tvalid;
        done       = udp_tx.tvalid && udp_tx.tready && udp_tx.tlast;
    end
    always_ff @(posedge udp_clk) begin
        state <= udp_areset ? IDLE : nxt;
    end
    always_comb begin
        nxt = idle ? (grant_ctrl ? CTRL : grant_data ? DATA : IDLE) : done ? IDLE : state;
    end
    always_comb begin
        udp_tx.tvalid = state == CTRL ? ctrl.tvalid : state == DATA && data.tvalid;
        udp_tx.tlast  = state == CTRL ? ctrl.tlast : state == DATA && data.tlast;
        udp_tx.tdata  = state == CTRL ? ctrl.tdata : state == DATA ? data.tdata : '0;
        udp_tx.tkeep  = state == CTRL ? ctrl.tkeep : state == DATA ? data.tkeep : '0;
        ctrl.tready   = state == CTRL && udp_tx.tready;
        data.tready   = state == DATA && udp_tx.tready;
        busy          = !idle;
    end
    always_ff @(posedge udp_clk) begin
        if (udp_areset) begin
            udp_tx.ip_dest   <= '0;
            udp_tx.port_dest <= '0;
            burst            <= '0;
            ctrl_pkt_cnt     <= '0;
            data_pkt_cnt     <= '0;
        end else begin
            if (idle && (grant_ctrl || grant_data)) begin
                udp_tx.ip_dest   <= grant_ctrl ? ctrl.ip_dest : data.ip_dest;
                udp_tx.port_dest <= grant_ctrl ? ctrl.port_dest : data.port_dest;
            end
            if (state == CTRL && done) ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
            if (state == DATA && done) data_pkt_cnt <= data_pkt_cnt + 32'd1;
            if (idle && (grant_data || !data.tvalid)) burst <= '0;
            else if (state == CTRL && done && burst < BURST_MAX) burst <= burst + 4'd1;
        end
    end
endmodule

// File: tb/tb_udt_tx_arbiter.sv
// tb_udt_tx_arbiter: scoreboard bench for the control/data transmit arbiter
module tb_udt_tx_arbiter;
    logic        udp_clk = 1'b0;
    logic        udp_areset = 1'b1;
    logic        arb_enable = 1'b0;
    logic [47:0] mac_src, mac_dest;
    logic [31:0] ip_src;
    logic [15:0] port_src;
    logic        busy;
    logic [31:0] ctrl_pkt_cnt, data_pkt_cnt;
    udt_tx_arbiter_if ctrl_if();
    udt_tx_arbiter_if data_if();
    udt_tx_arbiter_if tx_if();
    udt_tx_arbiter dut (
        .udp_clk(udp_clk), .udp_areset(udp_areset), .arb_enable(arb_enable),
        .ctrl(ctrl_if), .data(data_if), .udp_tx(tx_if),
        .udp_tx_mac_src(mac_src), .udp_tx_mac_dest(mac_dest),
        .udp_tx_ip_src(ip_src), .udp_tx_port_src(port_src), .busy(busy),
        .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt)
    );
    always #5 udp_clk = ~udp_clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [31:0] ip;
        logic [15:0] p;
    } beat_t;
    beat_t sb[$];
    int checks = 0;
    int failures = 0;
    int xfers = 0;

    function automatic logic [63:0] beat_data(bit c, logic [7:0] tag, int b);
        return {c ? 8'hC0 : 8'hD0, tag, 16'(b), 32'hA5A5_0000 + 32'(b)};
    endfunction
    function automatic logic [7:0] beat_keep(int b, int n);
        return b == n - 1 ? 8'h0F : 8'hFF;
    endfunction

    // Expected beats carry the destination latched at grant, not what the source shows later.
    task automatic push_pkt(bit c, int n, logic [31:0] ip, logic [15:0] p, logic [7:0] tag);
        for (int b = 0; b < n; b++)
            sb.push_back('{beat_data(c, tag, b), beat_keep(b, n), 1'(b == n - 1), ip, p});
    endtask

    task automatic set_src(bit c, logic v, logic [63:0] d, logic [7:0] k, logic l,
                           logic [31:0] ip, logic [15:0] p);
        if (c) begin
            ctrl_if.tvalid = v; ctrl_if.tdata = d; ctrl_if.tkeep = k; ctrl_if.tlast = l;
            ctrl_if.ip_dest = ip; ctrl_if.port_dest = p;
        end else begin
            data_if.tvalid = v; data_if.tdata = d; data_if.tkeep = k; data_if.tlast = l;
            data_if.ip_dest = ip; data_if.port_dest = p;
        end
    endtask

    task automatic send_pkt(bit c, int n, logic [31:0] ip, logic [15:0] p, logic [7:0] tag, bit gap);
        for (int b = 0; b < n; b++) begin
            int t;
            t = 0;
            set_src(c, 1'b1, beat_data(c, tag, b), beat_keep(b, n), 1'(b == n - 1),
                    b == 0 ? ip : ~ip, b == 0 ? p : ~p);
            do begin @(negedge udp_clk); t++; end
            while (!(c ? ctrl_if.tready : data_if.tready) && t < 300);
            if (!(c ? ctrl_if.tready : data_if.tready)) begin
                checks++; failures++;
                $display("FAIL handshake_timeout: src=%0d tag=%h beat=%0d got no tready, required tready within 300 cycles", c, tag, b);
            end
            @(posedge udp_clk); #1;
            if (gap && b < n - 1) begin
                set_src(c, 1'b0, '0, '0, 1'b0, '0, '0);
                @(posedge udp_clk); #1;
            end
        end
        set_src(c, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin @(negedge udp_clk); t++; end
        @(posedge udp_clk); #1;
        @(posedge udp_clk); #1;
    endtask

    always @(negedge udp_clk) begin
        beat_t e;
        if (!udp_areset && tx_if.tvalid && tx_if.tready) begin
            xfers++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got tdata=%h tlast=%b, required no transfer", tx_if.tdata, tx_if.tlast);
            end else begin
                e = sb.pop_front();
                if ({tx_if.tdata, tx_if.tkeep, tx_if.tlast, tx_if.ip_dest, tx_if.port_dest} !==
                    {e.d, e.k, e.l, e.ip, e.p}) begin
                    failures++;
                    $display("FAIL sb_beat: got d=%h k=%h l=%b ip=%h p=%h, required d=%h k=%h l=%b ip=%h p=%h",
                             tx_if.tdata, tx_if.tkeep, tx_if.tlast, tx_if.ip_dest, tx_if.port_dest,
                             e.d, e.k, e.l, e.ip, e.p);
                end
            end
        end
    end

    task automatic test_reset();
        udp_areset = 1'b1;
        tx_if.tready = 1'b1;
        set_src(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        set_src(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        repeat (3) @(posedge udp_clk);
        #1;
        @(negedge udp_clk);
        checks++;
        if ({tx_if.tvalid, ctrl_if.tready, data_if.tready, busy} !== 4'b0) begin
            failures++;
            $display("FAIL reset_handshake: got tvalid/ctrl_rdy/data_rdy/busy=%b, required 0000",
                     {tx_if.tvalid, ctrl_if.tready, data_if.tready, busy});
        end
        checks++;
        if ({ctrl_pkt_cnt, data_pkt_cnt, tx_if.ip_dest, tx_if.port_dest} !== 112'b0) begin
            failures++;
            $display("FAIL reset_regs: got cc=%h dc=%h ip=%h port=%h, required all 0",
                     ctrl_pkt_cnt, data_pkt_cnt, tx_if.ip_dest, tx_if.port_dest);
        end
        checks++;
        if (mac_src !== 48'hba0203040506 || mac_dest !== 48'hffffffffffff ||
            ip_src !== 32'hc0a8006f || port_src !== 16'd10086) begin
            failures++;
            $display("FAIL reset_consts: got %h %h %h %0d, required ba0203040506 ffffffffffff c0a8006f 10086",
                     mac_src, mac_dest, ip_src, port_src);
        end
        @(posedge udp_clk); #1;
        udp_areset = 1'b0;
        arb_enable = 1'b1;
        @(posedge udp_clk); #1;
    endtask

    task automatic test_ctrl_single();
        int x0;
        x0 = xfers;
        push_pkt(1'b1, 3, 32'hc0a80010, 16'd9000, 8'h01);
        fork
            send_pkt(1'b1, 3, 32'hc0a80010, 16'd9000, 8'h01, 1'b0);
            begin
                @(negedge udp_clk);
                checks++;
                if (tx_if.tvalid !== 1'b0) begin
                    failures++; $display("FAIL ctrl_latency: got tvalid=%b in grant cycle, required 0", tx_if.tvalid);
                end
                @(negedge udp_clk);
                checks++;
                if (tx_if.tvalid !== 1'b1 || busy !== 1'b1) begin
                    failures++; $display("FAIL ctrl_first_beat: got tvalid=%b busy=%b, required 1 1", tx_if.tvalid, busy);
                end
            end
            repeat (6) begin
                @(negedge udp_clk);
                checks++;
                if (data_if.tready !== 1'b0) begin
                    failures++; $display("FAIL ctrl_data_tready: got %b, required 0", data_if.tready);
                end
            end
        join
        wait_drain();
        checks++;
        if (xfers - x0 !== 3 || ctrl_pkt_cnt !== 32'd1 || data_pkt_cnt !== 32'd0) begin
            failures++;
            $display("FAIL ctrl_counts: got xfers=%0d cc=%0d dc=%0d, required 3 1 0", xfers - x0, ctrl_pkt_cnt, data_pkt_cnt);
        end
        checks++;
        if (tx_if.ip_dest !== 32'hc0a80010 || tx_if.port_dest !== 16'd9000 || sb.size() !== 0) begin
            failures++;
            $display("FAIL ctrl_dest: got ip=%h port=%0d pending=%0d, required c0a80010 9000 0",
                     tx_if.ip_dest, tx_if.port_dest, sb.size());
        end
    endtask

    // Both sources stay valid; four control packets then one forced data packet, twice.
    task automatic test_burst();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++)
                push_pkt(1'b1, 2, 32'h0a000100 + 32'(g * 4 + i), 16'(5000 + g * 4 + i), 8'(8'h10 + g * 4 + i));
            push_pkt(1'b0, 2, 32'h0a000200 + 32'(g), 16'(6000 + g), 8'(8'h20 + g));
        end
        fork
            for (int i = 0; i < 8; i++)
                send_pkt(1'b1, 2, 32'h0a000100 + 32'(i), 16'(5000 + i), 8'(8'h10 + i), 1'b0);
            for (int j = 0; j < 2; j++)
                send_pkt(1'b0, 2, 32'h0a000200 + 32'(j), 16'(6000 + j), 8'(8'h20 + j), 1'b0);
        join
        wait_drain();
        checks++;
        if (ctrl_pkt_cnt !== 32'd9 || data_pkt_cnt !== 32'd2 || sb.size() !== 0) begin
            failures++;
            $display("FAIL burst_counts: got cc=%0d dc=%0d pending=%0d, required 9 2 0", ctrl_pkt_cnt, data_pkt_cnt, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int x0;
        bit fin;
        x0 = xfers;
        fin = 1'b0;
        push_pkt(1'b0, 5, 32'h0a000300, 16'd7000, 8'h30);
        fork
            begin send_pkt(1'b0, 5, 32'h0a000300, 16'd7000, 8'h30, 1'b1); fin = 1'b1; end
            begin
                while (!fin) begin @(posedge udp_clk); #1; tx_if.tready = ~tx_if.tready; end
                tx_if.tready = 1'b1;
            end
            while (!fin) begin
                @(negedge udp_clk);
                if (busy) begin
                    checks++;
                    if (data_if.tready !== tx_if.tready) begin
                        failures++; $display("FAIL bp_mirror: got data_tready=%b, required %b", data_if.tready, tx_if.tready);
                    end
                end
            end
        join
        wait_drain();
        checks++;
        if (xfers - x0 !== 5 || data_pkt_cnt !== 32'd3 || sb.size() !== 0) begin
            failures++;
            $display("FAIL bp_counts: got xfers=%0d dc=%0d pending=%0d, required 5 3 0", xfers - x0, data_pkt_cnt, sb.size());
        end
    endtask

    task automatic test_arb_enable();
        int t;
        t = 0;
        push_pkt(1'b0, 4, 32'h0a000400, 16'd7100, 8'h40);
        push_pkt(1'b1, 2, 32'h0a000401, 16'd7101, 8'h41);
        fork send_pkt(1'b0, 4, 32'h0a000400, 16'd7100, 8'h40, 1'b0); join_none
        @(posedge udp_clk); #1;
        @(posedge udp_clk); #1;
        arb_enable = 1'b0;
        fork send_pkt(1'b1, 2, 32'h0a000401, 16'd7101, 8'h41, 1'b0); join_none
        while (data_pkt_cnt !== 32'd4 && t < 50) begin @(negedge udp_clk); t++; end
        checks++;
        if (data_pkt_cnt !== 32'd4) begin
            failures++; $display("FAIL en_data_done: got dc=%0d, required 4", data_pkt_cnt);
        end
        repeat (4) begin
            @(negedge udp_clk);
            checks++;
            if (busy !== 1'b0 || tx_if.tvalid !== 1'b0) begin
                failures++; $display("FAIL en_hold: got busy=%b tvalid=%b while disabled, required 0 0", busy, tx_if.tvalid);
            end
        end
        @(posedge udp_clk); #1;
        arb_enable = 1'b1;
        @(negedge udp_clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL en_latency: got busy=%b in grant cycle, required 0", busy);
        end
        @(negedge udp_clk);
        checks++;
        if (busy !== 1'b1 || tx_if.tdata[63:56] !== 8'hC0) begin
            failures++; $display("FAIL en_ctrl_grant: got busy=%b src=%h, required 1 c0", busy, tx_if.tdata[63:56]);
        end
        wait_drain();
        checks++;
        if (ctrl_pkt_cnt !== 32'd10 || sb.size() !== 0) begin
            failures++; $display("FAIL en_counts: got cc=%0d pending=%0d, required 10 0", ctrl_pkt_cnt, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        sb.push_back('{beat_data(1'b1, 8'h50, 0), 8'hFF, 1'b0, 32'h0a000500, 16'd7200});
        set_src(1'b1, 1'b1, beat_data(1'b1, 8'h50, 0), 8'hFF, 1'b0, 32'h0a000500, 16'd7200);
        @(posedge udp_clk); #1;
        @(posedge udp_clk); #1;
        set_src(1'b1, 1'b1, beat_data(1'b1, 8'h50, 1), 8'hFF, 1'b0, 32'hf5fffaff, 16'd1);
        udp_areset = 1'b1;
        @(posedge udp_clk); #1;
        udp_areset = 1'b0;
        set_src(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        push_pkt(1'b0, 1, 32'h0a000501, 16'd7201, 8'h51);
        fork send_pkt(1'b0, 1, 32'h0a000501, 16'd7201, 8'h51, 1'b0); join_none
        @(negedge udp_clk);
        checks++;
        if ({tx_if.tvalid, ctrl_if.tready, data_if.tready, busy} !== 4'b0 || sb.size() !== 1) begin
            failures++;
            $display("FAIL rst_mid_idle: got tvalid/crdy/drdy/busy=%b pending=%0d, required 0000 1",
                     {tx_if.tvalid, ctrl_if.tready, data_if.tready, busy}, sb.size());
        end
        checks++;
        if ({ctrl_pkt_cnt, data_pkt_cnt, tx_if.ip_dest, tx_if.port_dest} !== 112'b0) begin
            failures++;
            $display("FAIL rst_mid_regs: got cc=%h dc=%h ip=%h port=%h, required all 0",
                     ctrl_pkt_cnt, data_pkt_cnt, tx_if.ip_dest, tx_if.port_dest);
        end
        @(negedge udp_clk);
        checks++;
        if (busy !== 1'b1 || tx_if.tdata[63:56] !== 8'hD0) begin
            failures++; $display("FAIL rst_mid_data_grant: got busy=%b src=%h, required 1 d0", busy, tx_if.tdata[63:56]);
        end
        wait_drain();
        checks++;
        if (data_pkt_cnt !== 32'd1 || ctrl_pkt_cnt !== 32'd0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL rst_mid_counts: got cc=%0d dc=%0d pending=%0d, required 0 1 0", ctrl_pkt_cnt, data_pkt_cnt, sb.size());
        end
    endtask

    task automatic test_wrap();
        @(negedge udp_clk);
        force dut.data_pkt_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.data_pkt_cnt;
        @(posedge udp_clk); #1;
        push_pkt(1'b0, 1, 32'h0a000600, 16'd4321, 8'h60);
        send_pkt(1'b0, 1, 32'h0a000600, 16'd4321, 8'h60, 1'b0);
        wait_drain();
        checks++;
        if (data_pkt_cnt !== 32'd0 || sb.size() !== 0) begin
            failures++; $display("FAIL wrap_count: got dc=%h pending=%0d, required 00000000 0", data_pkt_cnt, sb.size());
        end
        checks++;
        if (tx_if.ip_dest !== 32'h0a000600 || tx_if.port_dest !== 16'd4321) begin
            failures++; $display("FAIL wrap_dest: got ip=%h port=%0d, required 0a000600 4321", tx_if.ip_dest, tx_if.port_dest);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ctrl_single();
        test_burst();
        test_backpressure();
        test_arb_enable();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udt_tx_arbiter.md
Name: udt_tx_arbiter

Overview:
- Packet-atomic 2:1 arbiter that shares the single UDP transmit channel (udp_tx_*) between the UDT control-packet generator (ACK/NAK/keep-alive/handshake) and the UDT data-packet path.
- Control packets have priority. A burst limit prevents data starvation.
- Latches the per-packet destination IP and port at grant. Drives the constant source MAC, IP and port.
- Sits in the udp_clk domain, between the UDT core and the UDP/IP stack.

Parameters:
- MAX_CTRL_BURST, 4, number of consecutive control packets granted while data is pending before one data packet is forced (range 1..15).
- FPGA_MAC_SRC, 48'hba0203040506, source MAC driven on udp_tx_mac_src.
- FPGA_MAC_DES, 48'hffffffffffff, destination MAC driven on udp_tx_mac_dest.
- FPGA_IP_SRC, 32'hc0a8006f, source IP driven on udp_tx_ip_src.
- PORT, 10086, source port driven on udp_tx_port_src (low 16 bits).

Ports:
- udp_clk  in  1  clock (156 MHz)
- udp_areset  in  1  synchronous reset, active-high
- arb_enable  in  1  1 = grants allowed; 0 = finish the current packet, then stop granting
- ctrl_tvalid/ctrl_tready/ctrl_tlast  in/out/in  1  control packet AXIS handshake
- ctrl_tdata  in  64  control packet data
- ctrl_tkeep  in  8  control byte enables
- ctrl_ip_dest  in  32  destination IP; valid with the first ctrl beat
- ctrl_port_dest  in  16  destination port; valid with the first ctrl beat
- data_tvalid/data_tready/data_tlast  in/out/in  1  data packet AXIS handshake
- data_tdata  in  64  data packet data
- data_tkeep  in  8  data byte enables
- data_ip_dest  in  32  destination IP; valid with the first data beat
- data_port_dest  in  16  destination port; valid with the first data beat
- udp_tx_tready  in  1  UDP stack ready
- udp_tx_tvalid/udp_tx_tlast  out  1  to UDP stack
- udp_tx_tdata  out  64  to UDP stack
- udp_tx_tkeep  out  8  to UDP stack
- udp_tx_mac_src/udp_tx_mac_dest  out  48  MAC addresses
- udp_tx_ip_src/udp_tx_ip_dest  out  32  IP addresses
- udp_tx_port_src/udp_tx_port_dest  out  16  ports
- busy  out  1  a packet is in flight
- ctrl_pkt_cnt  out  32  completed control packets
- data_pkt_cnt  out  32  completed data packets

Behaviour:
- States: IDLE, CTRL, DATA. Reset forces IDLE from any state, including mid-packet.
- Reset values:
  - all tready and tvalid outputs 0
  - udp_tx_ip_dest = 0, udp_tx_port_dest = 0
  - busy = 0, counters = 0, burst counter = 0
- Constant outputs: mac_src = FPGA_MAC_SRC, mac_dest = FPGA_MAC_DES, ip_src = FPGA_IP_SRC, port_src = PORT[15:0]. These are driven during reset as well.
- Grant decision in IDLE, evaluated each cycle when arb_enable = 1:
  - ctrl_tvalid=1 and (data_tvalid=0 or burst < MAX_CTRL_BURST) -> CTRL.
  - Otherwise data_tvalid=1 -> DATA.
  - Otherwise stay in IDLE.
- On grant, register the winner's ip_dest/port_dest into udp_tx_ip_dest/udp_tx_port_dest. These hold until the next grant.
- Grant latency: 1 cycle. A source seen valid in cycle N presents its first beat on udp_tx in cycle N+1.
- In CTRL/DATA the path is combinational pass-through:
  - udp_tx_tvalid/tdata/tkeep/tlast = the selected source's signals.
  - selected tready = udp_tx_tready.
  - the unselected tready = 0.
- A transfer occurs when udp_tx_tvalid & udp_tx_tready. The packet ends on a transfer with tlast=1; the state then returns to IDLE.
- There is a mandatory 1 IDLE cycle between packets, so the minimum packet-to-packet gap is 1 cycle.
- Burst counter (4 bits):
  - +1 on CTRL packet completion, saturating at MAX_CTRL_BURST.
  - cleared on DATA grant.
  - cleared on any IDLE cycle where data_tvalid=0.
- busy = 1 in CTRL/DATA.
- Packet counters increment on the tlast transfer of the respective source and wrap at 2^32.
- arb_enable=0 while in CTRL/DATA: the packet completes normally, with no truncation. arb_enable affects only the grant in IDLE.
- A source deasserting tvalid mid-packet stalls the output (udp_tx_tvalid=0). There is no timeout and no re-arbitration until tlast.
- Single-beat packet (tlast on the first beat): 1 transfer cycle, then IDLE.
- Simultaneous ctrl/data valid with burst = MAX: DATA wins, and the burst counter clears on that grant.
- Mid-packet reset: the output is truncated without tlast. Upstream FIFOs are reset by the same udp_areset.

Test Plan:
- Single ctrl packet, 3 beats, ip=c0a80010, port=9000, udp_tx_tready=1 -> first beat on udp_tx one cycle after ctrl_tvalid; 3 transfers; ip_dest=c0a80010, port_dest=9000; ctrl_pkt_cnt=1; data_tready stays 0.
- Both sources continuously valid, MAX_CTRL_BURST=4 -> grant sequence C,C,C,C,D,C,C,C,C,D; counters 8/2 after 10 packets.
- Backpressure: udp_tx_tready toggles 1/0 during a 5-beat data packet -> exactly 5 transfers; data_tready mirrors udp_tx_tready; no beat lost or duplicated.
- arb_enable dropped on beat 2 of a 4-beat data packet, ctrl pending -> data packet completes (tlast seen); no ctrl grant until arb_enable=1, then ctrl granted one cycle later.
- udp_areset asserted on beat 2 of a ctrl packet -> next cycle all tvalid/tready = 0, busy=0, counters=0; after release, a pending data packet is granted from IDLE.
- Wrap: preset or force data_pkt_cnt=FFFFFFFF, send 1 single-beat data packet -> counter=0; ip/port latched from the single beat.
